// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/stall/flush controller for the 5-stage pipeline.
// Optional perf counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_wreg_i,
  input  logic        ex_is_load_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_busy_i,
  input  logic        if_busy_i,
  output logic [1:0]  pc_ctrl_o,
  output logic [1:0]  if_id_ctrl_o,
  output logic [1:0]  id_ex_ctrl_o,
  output logic [1:0]  ex_mem_ctrl_o,
  output logic [1:0]  mem_wb_ctrl_o,
  output logic        pc_redirect_o,
  output logic        mem_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [1:0]  CtrlDefault = 2'b00;
  localparam logic [1:0]  CtrlStalled = 2'b01;
  localparam logic [1:0]  CtrlBubble  = 2'b10;
  localparam logic [2:0]  FlushInit   = 3'(FLUSH_CYCLES - 1);
  localparam bit          FlushMulti  = (FLUSH_CYCLES > 1);
  localparam logic [15:0] TimeoutVal  = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        timeout_q, timeout_d;
  logic        load_use;
  logic        flush_active;

  assign load_use = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  // A flush interrupted by a memory wait keeps its remaining count across MEM_WAIT.
  assign flush_active = ((state_q == StFlush) || (state_q == StMemWait)) && (flush_cnt_q != 3'd0);

  always_comb begin
    pc_ctrl_o     = CtrlDefault;
    if_id_ctrl_o  = CtrlDefault;
    id_ex_ctrl_o  = CtrlDefault;
    ex_mem_ctrl_o = CtrlDefault;
    mem_wb_ctrl_o = CtrlDefault;
    pc_redirect_o = 1'b0;
    state_d       = StRun;
    wait_cnt_d    = '0;
    flush_cnt_d   = flush_cnt_q;
    timeout_d     = timeout_q;

    if (mem_busy_i) begin
      pc_ctrl_o     = CtrlStalled;
      if_id_ctrl_o  = CtrlStalled;
      id_ex_ctrl_o  = CtrlStalled;
      ex_mem_ctrl_o = CtrlStalled;
      mem_wb_ctrl_o = CtrlBubble;
      state_d       = StMemWait;
      wait_cnt_d    = (wait_cnt_q == TimeoutVal) ? wait_cnt_q : 16'(wait_cnt_q + 16'd1);
      if (wait_cnt_d == TimeoutVal) begin
        timeout_d = 1'b1;
      end
    end else if (ex_branch_taken_i) begin
      pc_redirect_o = 1'b1;
      if_id_ctrl_o  = CtrlBubble;
      id_ex_ctrl_o  = CtrlBubble;
      if (FlushMulti) begin
        state_d     = StFlush;
        flush_cnt_d = FlushInit;
      end else begin
        flush_cnt_d = 3'd0;
      end
    end else if (load_use) begin
      pc_ctrl_o    = CtrlStalled;
      if_id_ctrl_o = CtrlStalled;
      id_ex_ctrl_o = CtrlBubble;
      state_d      = flush_active ? StFlush : StRun;
    end else if (flush_active) begin
      if_id_ctrl_o = CtrlBubble;
      flush_cnt_d  = flush_cnt_q - 3'd1;
      state_d      = (flush_cnt_d != 3'd0) ? StFlush : StRun;
    end else if (if_busy_i) begin
      pc_ctrl_o    = CtrlStalled;
      if_id_ctrl_o = CtrlBubble;
    end

    if (rst) begin
      pc_ctrl_o     = CtrlBubble;
      if_id_ctrl_o  = CtrlBubble;
      id_ex_ctrl_o  = CtrlBubble;
      ex_mem_ctrl_o = CtrlBubble;
      mem_wb_ctrl_o = CtrlBubble;
      pc_redirect_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_timeout_o = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_perf_q, flush_cnt_perf_d;

  always_comb begin
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_perf_d = flush_cnt_perf_q;
    if (pc_ctrl_o == CtrlStalled) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pc_redirect_o) begin
      flush_cnt_perf_d = flush_cnt_perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q      <= '0;
      flush_cnt_perf_q <= '0;
    end else begin
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_perf_q <= flush_cnt_perf_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_perf_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
